// File: rtl/uart_tx_ctrl_if.sv
// CPU-side configuration, TX buffer write and status bundle for the UART
// transmit sequencer. The CPU register block drives it as master and the
// sequencer consumes it as slave.
interface uart_tx_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16
);
  logic              uart_en;
  logic [BAUD_W-1:0] uart_baud;
  logic              prty_en;
  logic              prty_odd;
  logic              txie;
  logic              txbuf_wr;
  logic [DATA_W-1:0] txbuf_wdat;
  logic              txpnd_clr;
  logic              tx_busy;
  logic              tx_pnd;
  logic              tx_ovf;
  logic              tx_int;

  modport master (
    output uart_en, uart_baud, prty_en, prty_odd, txie,
           txbuf_wr, txbuf_wdat, txpnd_clr,
    input  tx_busy, tx_pnd, tx_ovf, tx_int
  );

  modport slave (
    input  uart_en, uart_baud, prty_en, prty_odd, txie,
           txbuf_wr, txbuf_wdat, txpnd_clr,
    output tx_busy, tx_pnd, tx_ovf, tx_int
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: one-entry holding register feeding a shift
// register, framing each byte as start, 8 data bits LSB first, optional
// parity, stop. Sticky completion and overflow flags plus a gated interrupt.
//
// state | meaning
// IDLE  | line high, waiting for a held byte
// START | driving the start bit (low)
// DATA  | driving shift[0], 8 bits LSB first
// PRTY  | driving the parity bit of the loaded byte
// STOP  | driving the stop bit (high); may chain straight into START
module uart_tx_ctrl #(
  parameter int DATA_W = 8,
  parameter int BAUD_W = 16
) (
  input  logic           uart_clk,
  input  logic           sys_rstn,
  uart_tx_ctrl_if.slave  bus,
  output logic           uart_tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PRTY, STOP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              prty_en_q, prty_en_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              pnd_q, pnd_d;
  logic              ovf_q, ovf_d;
  logic              load_d;
  logic              pnd_set_d;
  logic              ovf_set_d;
  logic              bit_end_d;

  // Next-state, buffer handshake and registered-output precompute
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    shift_d    = shift_q;
    data_d     = data_q;
    prty_en_d  = prty_en_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    load_d     = 1'b0;
    pnd_set_d  = 1'b0;
    ovf_set_d  = 1'b0;
    bit_end_d  = (baud_cnt_q == '0);

    if (!bus.uart_en) begin
      // abort: drop frame and held byte, keep sticky flags
      state_d    = IDLE;
      hold_vld_d = 1'b0;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      if (state_q != IDLE) begin
        baud_cnt_d = bit_end_d ? bus.uart_baud : baud_cnt_q - BAUD_W'(1);
      end
      unique case (state_q)
        IDLE:  load_d = hold_vld_q;
        START: if (bit_end_d) begin
                 state_d   = DATA;
                 bit_cnt_d = '0;
               end
        DATA:  if (bit_end_d) begin
                 shift_d   = shift_q >> 1;
                 bit_cnt_d = bit_cnt_q + 3'd1;
                 if (bit_cnt_q == 3'd7) state_d = prty_en_q ? PRTY : STOP;
               end
        PRTY:  if (bit_end_d) state_d = STOP;
        STOP:  if (bit_end_d) begin
                 pnd_set_d = 1'b1;
                 if (hold_vld_q) load_d = 1'b1;
                 else            state_d = IDLE;
               end
        default: state_d = IDLE;
      endcase

      // move held byte into the shifter; parity enable is frozen per frame
      if (load_d) begin
        shift_d    = hold_q;
        data_d     = hold_q;
        prty_en_d  = bus.prty_en;
        hold_vld_d = 1'b0;
        baud_cnt_d = bus.uart_baud;
        state_d    = START;
      end

      // a write lands if the holder is empty or is being emptied this edge
      if (bus.txbuf_wr) begin
        if (!hold_vld_q || load_d) begin
          hold_d     = bus.txbuf_wdat;
          hold_vld_d = 1'b1;
        end else begin
          ovf_set_d  = 1'b1;
        end
      end
    end

    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PRTY:    tx_d = (^data_d) ^ bus.prty_odd;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE) | hold_vld_d;
    pnd_d  = pnd_set_d ? 1'b1 : (bus.txpnd_clr ? 1'b0 : pnd_q);
    ovf_d  = ovf_set_d ? 1'b1 : (bus.txpnd_clr ? 1'b0 : ovf_q);
  end

  // FSM, datapath and registered outputs; reset forces the line high at once
  always_ff @(posedge uart_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      prty_en_q  <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      pnd_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      prty_en_q  <= prty_en_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      pnd_q      <= pnd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign uart_tx     = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_pnd  = pnd_q;
  assign bus.tx_ovf  = ovf_q;
  assign bus.tx_int  = pnd_q & bus.txie;

endmodule
